cmp_stream_monitor: RTL and testbench

- Downstream consumer of the 4-bit magnitude comparator function, packaged as a stream stage.
- Accepts (A, B) sample pairs over a valid/ready handshake and produces the registered one-hot compare result on an output handshake.
- Keeps saturating per-outcome event counters.
- Runs a persistence FSM that raises an alarm when A>B holds for PERSIST consecutive accepted samples.

---
 rtl/cmp_stream_monitor.sv | 149 ++++++++++++++
 tb/tb_cmp_stream_monitor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_stream_monitor.sv
// Stream stage: registered one-hot magnitude compare of (A, B), saturating outcome counters and an A>B persistence alarm.
// Define CMP_MON_STICKY_ALARM_EN to make the alarm sticky until clr or reset.
module cmp_stream_monitor #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_grt_B,
  output logic             A_less_B,
  output logic             A_eq_B,
  output logic [CNT_W-1:0] grt_cnt,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [7:0]       run_len,
  output logic             alarm
);

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  localparam logic [7:0] PERSIST_L = 8'(PERSIST);

  state_t           r_state;
  logic             r_outValid;
  logic             r_grt;
  logic             r_less;
  logic             r_eq;
  logic [CNT_W-1:0] r_grtCnt;
  logic [CNT_W-1:0] r_lessCnt;
  logic [CNT_W-1:0] r_eqCnt;
  logic [7:0]       r_runLen;
  logic             r_alarm;

  logic w_inReady;
  logic w_accept;
  logic w_grt;
  logic w_less;
  logic w_eq;

  assign w_inReady = !r_outValid || out_ready;
  assign w_accept  = in_valid && w_inReady;
  assign w_grt     = (A > B);
  assign w_less    = (A < B);
  assign w_eq      = (A == B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_grt      <= 1'b0;
      r_less     <= 1'b0;
      r_eq       <= 1'b0;
      r_grtCnt   <= '0;
      r_lessCnt  <= '0;
      r_eqCnt    <= '0;
      r_runLen   <= '0;
      r_alarm    <= 1'b0;
      r_state    <= IDLE;
    end else begin
      if (w_accept) begin
        r_outValid <= 1'b1;
        r_grt      <= w_grt;
        r_less     <= w_less;
        r_eq       <= w_eq;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end

      // clr wins over a same-cycle accept for counters and FSM; the sample is still delivered above.
      if (clr) begin
        r_grtCnt  <= '0;
        r_lessCnt <= '0;
        r_eqCnt   <= '0;
        r_runLen  <= '0;
        r_alarm   <= 1'b0;
        r_state   <= IDLE;
      end else if (w_accept) begin
        if (w_grt && r_grtCnt != '1)   r_grtCnt  <= r_grtCnt + 1'b1;
        if (w_less && r_lessCnt != '1) r_lessCnt <= r_lessCnt + 1'b1;
        if (w_eq && r_eqCnt != '1)     r_eqCnt   <= r_eqCnt + 1'b1;

        case (r_state)
          IDLE: begin
            if (w_grt) begin
              r_runLen <= 8'd1;
              if (PERSIST_L == 8'd1) begin
                r_state <= ALARM;
                r_alarm <= 1'b1;
              end else begin
                r_state <= RUN;
              end
            end
          end
          RUN: begin
            if (w_grt) begin
              r_runLen <= r_runLen + 8'd1;
              if (r_runLen + 8'd1 == PERSIST_L) begin
                r_state <= ALARM;
                r_alarm <= 1'b1;
              end
            end else begin
              r_runLen <= '0;
              r_state  <= IDLE;
            end
          end
          ALARM: begin
            // run_len saturates at PERSIST; a sticky alarm may be re-counting a fresh streak here.
            if (w_grt) begin
              if (r_runLen < PERSIST_L) r_runLen <= r_runLen + 8'd1;
            end else begin
              r_runLen <= '0;
`ifdef CMP_MON_STICKY_ALARM_EN
              r_state  <= ALARM;
              r_alarm  <= 1'b1;
`else
              r_state  <= IDLE;
              r_alarm  <= 1'b0;
`endif
            end
          end
          default: begin
            r_state  <= IDLE;
            r_runLen <= '0;
            r_alarm  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign A_grt_B   = r_grt;
  assign A_less_B  = r_less;
  assign A_eq_B    = r_eq;
  assign grt_cnt   = r_grtCnt;
  assign less_cnt  = r_lessCnt;
  assign eq_cnt    = r_eqCnt;
  assign run_len   = r_runLen;
  assign alarm     = r_alarm;

endmodule

// File: tb/tb_cmp_stream_monitor.sv
// Directed self-checking bench for cmp_stream_monitor (default parameters).
module tb_cmp_stream_monitor;

`ifdef CMP_MON_STICKY_ALARM_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic [3:0] B;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic       A_grt_B;
  logic       A_less_B;
  logic       A_eq_B;
  logic [7:0] grt_cnt;
  logic [7:0] less_cnt;
  logic [7:0] eq_cnt;
  logic [7:0] run_len;
  logic       alarm;

  int checks = 0;
  int passes = 0;

  cmp_stream_monitor #(.WIDTH(4), .CNT_W(8), .PERSIST(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .A_grt_B(A_grt_B), .A_less_B(A_less_B), .A_eq_B(A_eq_B),
    .grt_cnt(grt_cnt), .less_cnt(less_cnt), .eq_cnt(eq_cnt),
    .run_len(run_len), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    A = a;
    B = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1; A = '0; B = '0;
    tick(); tick();
    checks++;
    if ({out_valid, A_grt_B, A_less_B, A_eq_B, in_ready} !== 5'b00001) $display("[TB] FAIL reset_flags got=%b exp=00001", {out_valid, A_grt_B, A_less_B, A_eq_B, in_ready});
    else passes++;
    checks++;
    if ({grt_cnt, less_cnt, eq_cnt, run_len, alarm} !== 33'd0) $display("[TB] FAIL reset_state got=%h exp=0", {grt_cnt, less_cnt, eq_cnt, run_len, alarm});
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_first_sample();
    send(4'd9, 4'd3);
    checks++;
    if ({out_valid, A_grt_B, A_less_B, A_eq_B} !== 4'b1100) $display("[TB] FAIL first_result got=%b exp=1100", {out_valid, A_grt_B, A_less_B, A_eq_B});
    else passes++;
    checks++;
    if ({grt_cnt, run_len, alarm} !== {8'd1, 8'd1, 1'b0}) $display("[TB] FAIL first_state got=%0d/%0d/%b exp=1/1/0", grt_cnt, run_len, alarm);
    else passes++;
    tick();
    checks++;
    if ({out_valid, A_grt_B} !== 2'b01) $display("[TB] FAIL drain_hold got=%b exp=01", {out_valid, A_grt_B});
    else passes++;
  endtask

  task automatic test_exhaustive();
    logic [2:0] exp;
    pulse_clr();
    out_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        in_valid = 1'b1;
        A = 4'(a);
        B = 4'(b);
        exp = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
        tick();
        checks++;
        if ({out_valid, in_ready, A_grt_B, A_less_B, A_eq_B} !== {2'b11, exp})
          $display("[TB] FAIL compare a=%0d b=%0d got=%b exp=%b", a, b, {out_valid, in_ready, A_grt_B, A_less_B, A_eq_B}, {2'b11, exp});
        else passes++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if ({grt_cnt, less_cnt, eq_cnt} !== {8'd120, 8'd120, 8'd16}) $display("[TB] FAIL exhaustive_counts got=%0d/%0d/%0d exp=120/120/16", grt_cnt, less_cnt, eq_cnt);
    else passes++;
    tick();
  endtask

  task automatic test_persistence();
    pulse_clr();
    send(4'd5, 4'd2);
    checks++;
    if ({run_len, alarm} !== {8'd1, 1'b0}) $display("[TB] FAIL persist_1 got=%0d/%b exp=1/0", run_len, alarm);
    else passes++;
    send(4'd7, 4'd1);
    checks++;
    if ({run_len, alarm} !== {8'd2, 1'b0}) $display("[TB] FAIL persist_2 got=%0d/%b exp=2/0", run_len, alarm);
    else passes++;
    send(4'd15, 4'd0);
    checks++;
    if ({out_valid, A_grt_B, run_len, alarm} !== {2'b11, 8'd3, 1'b1}) $display("[TB] FAIL persist_3 got=%b/%0d/%b exp=11/3/1", {out_valid, A_grt_B}, run_len, alarm);
    else passes++;
    send(4'd9, 4'd8);
    checks++;
    if ({run_len, alarm} !== {8'd3, 1'b1}) $display("[TB] FAIL persist_hold got=%0d/%b exp=3/1", run_len, alarm);
    else passes++;
    send(4'd4, 4'd4);
    checks++;
    if ({A_eq_B, run_len, alarm} !== {1'b1, 8'd0, STICKY}) $display("[TB] FAIL persist_break got=%b/%0d/%b exp=1/0/%b", A_eq_B, run_len, alarm, STICKY);
    else passes++;
    send(4'd6, 4'd1);
    checks++;
    if ({run_len, alarm} !== {8'd1, STICKY}) $display("[TB] FAIL persist_restart got=%0d/%b exp=1/%b", run_len, alarm, STICKY);
    else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    pulse_clr();
    out_ready = 1'b0;
    in_valid = 1'b1; A = 4'd2; B = 4'd6;
    tick();
    checks++;
    if ({out_valid, in_ready, A_less_B, less_cnt} !== {3'b101, 8'd1}) $display("[TB] FAIL bp_first got=%b/%0d exp=101/1", {out_valid, in_ready, A_less_B}, less_cnt);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, A_less_B, less_cnt} !== {3'b101, 8'd1}) $display("[TB] FAIL bp_hold%0d got=%b/%0d exp=101/1", i, {out_valid, in_ready, A_less_B}, less_cnt);
      else passes++;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready got=%b exp=1", in_ready);
    else passes++;
    tick();
    checks++;
    if ({out_valid, A_less_B, less_cnt} !== {2'b11, 8'd2}) $display("[TB] FAIL bp_resume got=%b/%0d exp=11/2", {out_valid, A_less_B}, less_cnt);
    else passes++;
    A = 4'd3; B = 4'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, A_eq_B, less_cnt, eq_cnt} !== {2'b11, 8'd2, 8'd1}) $display("[TB] FAIL bp_next got=%b/%0d/%0d exp=11/2/1", {out_valid, A_eq_B}, less_cnt, eq_cnt);
    else passes++;
    tick();
  endtask

  task automatic test_saturation_clr();
    pulse_clr();
    out_ready = 1'b1;
    in_valid = 1'b1; A = 4'd5; B = 4'd5;
    for (int i = 0; i < 254; i++) tick();
    checks++;
    if (eq_cnt !== 8'd254) $display("[TB] FAIL sat_pre got=%0d exp=254", eq_cnt);
    else passes++;
    for (int i = 0; i < 6; i++) tick();
    in_valid = 1'b0;
    checks++;
    if (eq_cnt !== 8'd255) $display("[TB] FAIL sat_eq got=%0d exp=255", eq_cnt);
    else passes++;
    send(4'd3, 4'd1);
    send(4'd3, 4'd1);
    send(4'd3, 4'd1);
    checks++;
    if (alarm !== 1'b1) $display("[TB] FAIL clr_pre_alarm got=%b exp=1", alarm);
    else passes++;
    clr = 1'b1;
    send(4'd8, 4'd1);
    clr = 1'b0;
    checks++;
    if ({grt_cnt, less_cnt, eq_cnt, run_len, alarm} !== 33'd0) $display("[TB] FAIL clr_state got=%0d/%0d/%0d/%0d/%b exp=0", grt_cnt, less_cnt, eq_cnt, run_len, alarm);
    else passes++;
    checks++;
    if ({out_valid, A_grt_B, A_less_B, A_eq_B} !== 4'b1100) $display("[TB] FAIL clr_delivery got=%b exp=1100", {out_valid, A_grt_B, A_less_B, A_eq_B});
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    pulse_clr();
    out_ready = 1'b1;
    send(4'd10, 4'd2);
    send(4'd11, 4'd2);
    send(4'd12, 4'd2);
    out_ready = 1'b0;
    tick();
    checks++;
    if ({out_valid, A_grt_B, alarm, in_ready} !== 4'b1110) $display("[TB] FAIL mid_pre got=%b exp=1110", {out_valid, A_grt_B, alarm, in_ready});
    else passes++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({out_valid, A_grt_B, A_less_B, A_eq_B, in_ready} !== 5'b00001) $display("[TB] FAIL mid_flags got=%b exp=00001", {out_valid, A_grt_B, A_less_B, A_eq_B, in_ready});
    else passes++;
    checks++;
    if ({grt_cnt, less_cnt, eq_cnt, run_len, alarm} !== 33'd0) $display("[TB] FAIL mid_state got=%h exp=0", {grt_cnt, less_cnt, eq_cnt, run_len, alarm});
    else passes++;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_exhaustive();
    test_persistence();
    test_backpressure();
    test_saturation_clr();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
